// File: rtl/dual_port_ram_pkg.sv
// Shared constants for the dual-port scratchpad RAM.
// Holds default word/address widths and the derived depth.
package dual_port_ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

endpackage

// File: rtl/dual_port_ram_port.sv
// One RAM access port: decodes en/we into read/write strobes and
// registers read data. Ports: clk, rst_n, en, we, rd_word -> rd, wr, out.
module dual_port_ram_port
  import dual_port_ram_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [DW-1:0] rd_word,
  output logic          rd,
  output logic          wr,
  output logic [DW-1:0] out
);

  logic [DW-1:0] out_d;
  logic [DW-1:0] out_q;

  assign rd = en & ~we;
  assign wr = en & we;

  // rd_word comes straight from the current array contents, so a
  // same-cycle write by either port is not seen (read-first).
  always_comb begin
    out_d = out_q;
    if (rd) out_d = rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM on a resettable flop array, one clock.
// Ports: clk, rst_n; per port en/we/ad/in -> out (registered).
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = dual_port_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dual_port_ram_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] ada,
  input  logic [DATA_WIDTH-1:0] ina,
  output logic [DATA_WIDTH-1:0] outa,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] adb,
  input  logic [DATA_WIDTH-1:0] inb,
  output logic [DATA_WIDTH-1:0] outb
);

  localparam int NW = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NW];
  logic [DATA_WIDTH-1:0] mem_d [NW];

  logic rd_a, wr_a;
  logic rd_b, wr_b;

  dual_port_ram_port #(.DW(DATA_WIDTH)) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ena),
    .we      (wea),
    .rd_word (mem_q[ada]),
    .rd      (rd_a),
    .wr      (wr_a),
    .out     (outa)
  );

  dual_port_ram_port #(.DW(DATA_WIDTH)) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (enb),
    .we      (web),
    .rd_word (mem_q[adb]),
    .rd      (rd_b),
    .wr      (wr_b),
    .out     (outb)
  );

  // B is applied first so that A overwrites it on an address clash.
  always_comb begin
    mem_d = mem_q;
    if (wr_b) mem_d[adb] = inb;
    if (wr_a) mem_d[ada] = ina;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  logic unused_rd;
  assign unused_rd = rd_a ^ rd_b;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
// Drives on the falling edge, checks one edge after each access.
module tb_dual_port_ram;

  logic       clk;
  logic       rst_n;
  logic       ena, wea, enb, web;
  logic [2:0] ada, adb;
  logic [7:0] ina, inb;
  logic [7:0] outa, outb;

  int tests;
  int fails;

  dual_port_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wea   (wea),
    .ada   (ada),
    .ina   (ina),
    .outa  (outa),
    .enb   (enb),
    .web   (web),
    .adb   (adb),
    .inb   (inb),
    .outb  (outb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ea, input logic wa,
                      input logic [2:0] aa, input logic [7:0] ia,
                      input logic eb, input logic wb,
                      input logic [2:0] ab, input logic [7:0] ib);
    ena = ea; wea = wa; ada = aa; ina = ia;
    enb = eb; web = wb; adb = ab; inb = ib;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ena = 0; wea = 0; ada = 0; ina = 0;
    enb = 0; web = 0; adb = 0; inb = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_outa", outa, 8'h00);
    check("rst_outb", outb, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      step(1, 1, 3'(i), 8'hA0 + 8'(i), 0, 0, 0, 0);
    check("a_wr_no_wt", outa, 8'h00);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 1, 3'(4 + i), 8'hB0 + 8'(i));
    check("b_wr_no_wt", outb, 8'h00);

    for (int i = 0; i < 4; i++) begin
      step(1, 0, 3'(i), 0, 1, 0, 3'(4 + i), 0);
      check($sformatf("a_rd%0d", i), outa, 8'hA0 + 8'(i));
      check($sformatf("b_rd%0d", 4 + i), outb, 8'hB0 + 8'(i));
    end

    for (int i = 0; i < 4; i++) begin
      step(1, 0, 3'(4 + i), 0, 1, 0, 3'(i), 0);
      check($sformatf("x_a%0d", 4 + i), outa, 8'hB0 + 8'(i));
      check($sformatf("x_b%0d", i), outb, 8'hA0 + 8'(i));
    end

    step(1, 0, 6, 0, 1, 0, 6, 0);
    check("same_a", outa, 8'hB2);
    check("same_b", outb, 8'hB2);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_a", outa, 8'hB2);
    check("hold_b", outb, 8'hB2);

    step(1, 1, 5, 8'h11, 1, 1, 5, 8'h22);
    step(1, 0, 5, 0, 1, 0, 5, 0);
    check("coll_a", outa, 8'h11);
    check("coll_b", outb, 8'h11);

    step(1, 1, 2, 8'h33, 1, 0, 2, 0);
    check("rfw_old", outb, 8'hA2);
    check("rfw_a_hold", outa, 8'h11);
    step(0, 0, 0, 0, 1, 0, 2, 0);
    check("rfw_new", outb, 8'h33);

    step(0, 1, 0, 8'hFF, 0, 1, 1, 8'hEE);
    check("gate_a", outa, 8'h11);
    check("gate_b", outb, 8'h33);
    step(1, 0, 0, 0, 1, 0, 1, 0);
    check("gate_mem_a", outa, 8'hA0);
    check("gate_mem_b", outb, 8'hA1);

    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", outa, 8'h00);
    check("mid_rst_b", outb, 8'h00);
    ena = 1; wea = 1; ada = 3; ina = 8'h55;
    enb = 1; web = 1; adb = 4; inb = 8'h66;
    @(posedge clk);
    @(negedge clk);
    check("rst_wr_a", outa, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(1, 0, 3'(i), 0, 1, 0, 3'(7 - i), 0);
      check($sformatf("clr_a%0d", i), outa, 8'h00);
      check($sformatf("clr_b%0d", 7 - i), outb, 8'h00);
    end

    step(1, 1, 7, 8'h5A, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 7, 0);
    check("post_rst_wr", outb, 8'h5A);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
